// File: rtl/fetch_if_id_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and the instruction memory.
interface fetch_if_id_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_if_id_stage.sv
// Instruction fetch with credit-limited in-order requests, 2-entry response queue and IF/ID register.
// EX redirects squash in-flight responses through a drop counter.
module fetch_if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_if_id_stage_if.master  imem,
    input  logic                 stall_d,
    input  logic                 flush_d,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 valid_d,
    output logic [XLEN-1:0]      instr_d,
    output logic [XLEN-1:0]      pc_d,
    output logic [XLEN-1:0]      pc_plus4_d
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SUM_W = 3;

    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] q_count;

    // In-flight PC FIFO: pairs each returning response with its fetch address
    logic [XLEN-1:0]  fl_pc [DEPTH];
    logic             fl_wr;
    logic             fl_rd;

    logic [XLEN-1:0]  q_pc   [DEPTH];
    logic [XLEN-1:0]  q_data [DEPTH];
    logic             q_wr;
    logic             q_rd;

    logic fire_c;
    logic rsp_c;
    logic drop_c;
    logic push_c;
    logic pop_c;

    // Credit: never more requests in flight than free queue slots
    assign imem.imem_req_valid = ((SUM_W'(outstanding) + SUM_W'(q_count)) < SUM_W'(DEPTH))
                                 & ~redirect_valid & rst_n;
    assign imem.imem_req_addr  = pc;

    assign fire_c = imem.imem_req_valid & imem.imem_req_ready;
    assign rsp_c  = imem.imem_rsp_valid;
    assign drop_c = rsp_c & (drop_cnt != '0);
    assign push_c = rsp_c & ~drop_c & ~redirect_valid;
    assign pop_c  = ~flush_d & ~stall_d & (q_count != '0);

    assign pc_plus4_d = pc_d + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin : p_fetch
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_count     <= '0;
            fl_wr       <= 1'b0;
            fl_rd       <= 1'b0;
            q_wr        <= 1'b0;
            q_rd        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fl_pc[i]  <= '0;
                q_pc[i]   <= '0;
                q_data[i] <= '0;
            end
        end else begin
            outstanding <= outstanding + CNT_W'(fire_c) - CNT_W'(rsp_c);
            if (fire_c) begin
                fl_pc[fl_wr] <= pc;
                fl_wr        <= ~fl_wr;
            end
            if (rsp_c) begin
                fl_rd <= ~fl_rd;
            end
            if (redirect_valid) begin
                // Everything still in flight, minus the response retiring now, is stale
                pc       <= redirect_pc & ~XLEN'(3);
                drop_cnt <= outstanding - CNT_W'(rsp_c);
                q_count  <= '0;
                q_wr     <= 1'b0;
                q_rd     <= 1'b0;
            end else begin
                if (fire_c) begin
                    pc <= pc + XLEN'(4);
                end
                if (drop_c) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
                if (push_c) begin
                    q_pc[q_wr]   <= fl_pc[fl_rd];
                    q_data[q_wr] <= imem.imem_rsp_data;
                    q_wr         <= ~q_wr;
                end
                if (pop_c) begin
                    q_rd <= ~q_rd;
                end
                q_count <= q_count + CNT_W'(push_c) - CNT_W'(pop_c);
            end
        end
    end

    // IF/ID register: flush beats stall beats load
    always_ff @(posedge clk or negedge rst_n) begin : p_ifid
        if (!rst_n) begin
            valid_d <= 1'b0;
            instr_d <= '0;
            pc_d    <= '0;
        end else if (flush_d) begin
            valid_d <= 1'b0;
            instr_d <= '0;
        end else if (stall_d) begin
            valid_d <= valid_d;
        end else if (pop_c) begin
            valid_d <= 1'b1;
            instr_d <= q_data[q_rd];
            pc_d    <= q_pc[q_rd];
        end else begin
            valid_d <= 1'b0;
            instr_d <= '0;
        end
    end

    a_queue_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_c && (q_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Randomized bench for fetch_if_id_stage: a memory model answers requests, and a queue-level
// reference model predicts request credit, decode output and redirect squashing.
module tb_fetch_if_id_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall_d;
    logic        flush_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;

    fetch_if_id_stage_if #(.XLEN(32)) imem ();

    fetch_if_id_stage #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .valid_d        (valid_d),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pc_plus4_d     (pc_plus4_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ready_pct;
    int rsp_pct;

    // memory side: accepted addresses awaiting a response
    logic [31:0] pend_addr [$];
    int          pend_cyc  [$];

    // reference model
    logic [31:0] infl_pc   [$];
    bit          infl_keep [$];
    logic [31:0] rq_pc     [$];
    logic [31:0] rq_data   [$];
    logic [31:0] model_pc;
    bit          ev;
    logic [31:0] ei;
    logic [31:0] ep;
    bit          erv;
    logic [31:0] era;
    logic        orv;
    logic [31:0] ora;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00a0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic model_reset();
        pend_addr.delete(); pend_cyc.delete();
        infl_pc.delete();   infl_keep.delete();
        rq_pc.delete();     rq_data.delete();
        model_pc = RESET_PC;
        ev = 1'b0; ei = '0; ep = '0;
    endtask

    // one clock: drive memory, sample request before the edge, advance model, land at posedge+1
    task automatic step();
        bit          r;
        logic [31:0] hp;
        r = (pend_addr.size() > 0) && (pend_cyc[0] < cyc) && (int'($urandom_range(99)) < rsp_pct);
        imem.imem_rsp_valid = r;
        imem.imem_rsp_data  = r ? word(pend_addr[0]) : $urandom();
        imem.imem_req_ready = (int'($urandom_range(99)) < ready_pct);
        #3;
        orv = imem.imem_req_valid;
        ora = imem.imem_req_addr;
        erv = ((infl_pc.size() + rq_pc.size()) < 2) && !redirect_valid;
        era = model_pc;
        if (flush_d) begin
            ev = 1'b0; ei = '0;
        end else if (!stall_d) begin
            if (rq_pc.size() > 0) begin
                ev = 1'b1; ei = rq_data.pop_front(); ep = rq_pc.pop_front();
            end else begin
                ev = 1'b0; ei = '0;
            end
        end
        if (r && infl_pc.size() > 0) begin
            hp = infl_pc.pop_front();
            if (infl_keep.pop_front() && !redirect_valid) begin
                rq_pc.push_back(hp);
                rq_data.push_back(word(hp));
            end
        end
        if (redirect_valid) begin
            foreach (infl_keep[i]) infl_keep[i] = 1'b0;
            rq_pc.delete(); rq_data.delete();
            model_pc = redirect_pc & ~32'h3;
        end else if (erv && imem.imem_req_ready) begin
            infl_pc.push_back(model_pc);
            infl_keep.push_back(1'b1);
            model_pc = model_pc + 32'd4;
        end
        if (r) begin
            void'(pend_addr.pop_front());
            void'(pend_cyc.pop_front());
        end
        if (orv && imem.imem_req_ready) begin
            pend_addr.push_back(ora);
            pend_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_d = 0; flush_d = 0; redirect_valid = 0; redirect_pc = '0;
        imem.imem_req_ready = 0; imem.imem_rsp_valid = 0; imem.imem_rsp_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({valid_d, instr_d, pc_d, pc_plus4_d} !== {1'b0, 32'h0, 32'h0, 32'h4}) begin
            n_fail++;
            $display("FAIL reset_ifid got v=%b i=%h pc=%h p4=%h exp 0/0/0/4", valid_d, instr_d, pc_d, pc_plus4_d);
        end
        n_cmp++;
        if (imem.imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_valid got %b exp 0", imem.imem_req_valid);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_first_req got v=%b a=%h exp 1/%h", imem.imem_req_valid, imem.imem_req_addr, RESET_PC);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        bit found = 0;
        ready_pct = 100; rsp_pct = 100;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            n_cmp++;
            if (orv !== erv || (erv && ora !== era)) begin
                n_fail++;
                $display("FAIL stream_req got v=%b a=%h exp v=%b a=%h", orv, ora, erv, era);
            end
            if (valid_d === 1'b1) found = 1;
        end
        n_cmp++;
        if (!found || {instr_d, pc_d, pc_plus4_d} !== {32'h0050_0093, 32'h0, 32'h4}) begin
            n_fail++;
            $display("FAIL stream_first got v=%b i=%h pc=%h p4=%h exp 1/00500093/0/4", valid_d, instr_d, pc_d, pc_plus4_d);
        end
        step();
        n_cmp++;
        if ({valid_d, instr_d, pc_d, pc_plus4_d} !== {1'b1, 32'h00a0_0113, 32'h4, 32'h8}) begin
            n_fail++;
            $display("FAIL stream_second got v=%b i=%h pc=%h p4=%h exp 1/00a00113/4/8", valid_d, instr_d, pc_d, pc_plus4_d);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if ({valid_d, instr_d, pc_d, pc_plus4_d} !== {ev, ei, ep, ep + 32'd4}) begin
                n_fail++;
                $display("FAIL stream_ifid cyc=%0d got v=%b i=%h pc=%h exp v=%b i=%h pc=%h", cyc, valid_d, instr_d, pc_d, ev, ei, ep);
            end
        end
    endtask

    task automatic test_stall();
        ready_pct = 100; rsp_pct = 100;
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({valid_d, instr_d, pc_d} !== {ev, ei, ep}) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d got v=%b i=%h pc=%h exp v=%b i=%h pc=%h", cyc, valid_d, instr_d, pc_d, ev, ei, ep);
            end
            n_cmp++;
            if (orv !== erv || (erv && ora !== era)) begin
                n_fail++;
                $display("FAIL stall_req got v=%b a=%h exp v=%b a=%h", orv, ora, erv, era);
            end
        end
        n_cmp++;
        if (orv !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_credit got req_valid=%b exp 0", orv);
        end
        stall_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if ({valid_d, instr_d, pc_d, pc_plus4_d} !== {ev, ei, ep, ep + 32'd4}) begin
                n_fail++;
                $display("FAIL stall_release cyc=%0d got v=%b i=%h pc=%h exp v=%b i=%h pc=%h", cyc, valid_d, instr_d, pc_d, ev, ei, ep);
            end
        end
    endtask

    // fill two in-flight requests, redirect (optionally with a same-cycle response), find target at decode
    task automatic run_redirect(input int same_rsp, input logic [31:0] target, input logic [31:0] exp_pc, input string tag);
        bit found = 0;
        ready_pct = 100; rsp_pct = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({valid_d, instr_d, pc_d} !== {ev, ei, ep} || orv !== erv || (erv && ora !== era)) begin
                n_fail++;
                $display("FAIL %s_fill cyc=%0d got v=%b pc=%h rv=%b exp v=%b pc=%h rv=%b", tag, cyc, valid_d, pc_d, orv, ev, ep, erv);
            end
        end
        redirect_valid = 1'b1; redirect_pc = target; flush_d = 1'b1;
        rsp_pct = same_rsp ? 100 : 0;
        step();
        n_cmp++;
        if (orv !== 1'b0 || valid_d !== 1'b0 || instr_d !== 32'h0) begin
            n_fail++;
            $display("FAIL %s_cycle got rv=%b v=%b i=%h exp 0/0/0", tag, orv, valid_d, instr_d);
        end
        redirect_valid = 1'b0; flush_d = 1'b0; rsp_pct = 100;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            n_cmp++;
            if ({valid_d, instr_d, pc_d} !== {ev, ei, ep} || orv !== erv || (erv && ora !== era)) begin
                n_fail++;
                $display("FAIL %s_after cyc=%0d got v=%b i=%h pc=%h exp v=%b i=%h pc=%h", tag, cyc, valid_d, instr_d, pc_d, ev, ei, ep);
            end
            if (valid_d === 1'b1) found = 1;
        end
        n_cmp++;
        if (!found || pc_d !== exp_pc || instr_d !== word(exp_pc)) begin
            n_fail++;
            $display("FAIL %s_target got found=%0d pc=%h i=%h exp pc=%h i=%h", tag, found, pc_d, instr_d, exp_pc, word(exp_pc));
        end
    endtask

    task automatic test_redirect();
        run_redirect(0, 32'h0000_0100, 32'h0000_0100, "redirect");
    endtask

    task automatic test_rsp_redirect();
        run_redirect(1, 32'h0000_0203, 32'h0000_0200, "rsp_redirect");
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        ready_pct = 0; rsp_pct = 100;
        held = model_pc;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (orv !== erv || ora !== held) begin
                n_fail++;
                $display("FAIL bp_addr cyc=%0d got v=%b a=%h exp v=%b a=%h", cyc, orv, ora, erv, held);
            end
            n_cmp++;
            if ({valid_d, instr_d, pc_d} !== {ev, ei, ep}) begin
                n_fail++;
                $display("FAIL bp_ifid cyc=%0d got v=%b i=%h pc=%h exp v=%b i=%h pc=%h", cyc, valid_d, instr_d, pc_d, ev, ei, ep);
            end
        end
        n_cmp++;
        if (valid_d !== 1'b0 || instr_d !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_bubble got v=%b i=%h exp 0/0", valid_d, instr_d);
        end
    endtask

    task automatic test_random();
        int k;
        ready_pct = 70; rsp_pct = 60;
        for (int i = 0; i < 400; i++) begin
            stall_d        = (int'($urandom_range(99)) < 20);
            k              = int'($urandom_range(99));
            redirect_valid = (k < 6);
            flush_d        = (k < 6) || (k > 96);
            redirect_pc    = $urandom() & 32'h0000_3fff;
            step();
            n_cmp++;
            if ({valid_d, instr_d, pc_d, pc_plus4_d} !== {ev, ei, ep, ep + 32'd4}) begin
                n_fail++;
                $display("FAIL rand_ifid cyc=%0d got v=%b i=%h pc=%h exp v=%b i=%h pc=%h", cyc, valid_d, instr_d, pc_d, ev, ei, ep);
            end
            n_cmp++;
            if (orv !== erv || (erv && ora !== era)) begin
                n_fail++;
                $display("FAIL rand_req cyc=%0d got v=%b a=%h exp v=%b a=%h", cyc, orv, ora, erv, era);
            end
        end
        stall_d = 0; flush_d = 0; redirect_valid = 0;
    endtask

    task automatic test_reset_midstream();
        ready_pct = 100; rsp_pct = 100;
        repeat (4) step();
        rst_n = 1'b0;
        imem.imem_req_ready = 0; imem.imem_rsp_valid = 0;
        #1;
        n_cmp++;
        if ({imem.imem_req_valid, valid_d, instr_d, pc_d, pc_plus4_d} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h4}) begin
            n_fail++;
            $display("FAIL midreset_state got rv=%b v=%b i=%h pc=%h p4=%h exp 0/0/0/0/4",
                     imem.imem_req_valid, valid_d, instr_d, pc_d, pc_plus4_d);
        end
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL midreset_first_req got v=%b a=%h exp 1/%h", imem.imem_req_valid, imem.imem_req_addr, RESET_PC);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if ({valid_d, instr_d, pc_d, pc_plus4_d} !== {ev, ei, ep, ep + 32'd4} || orv !== erv || (erv && ora !== era)) begin
                n_fail++;
                $display("FAIL midreset_stream cyc=%0d got v=%b i=%h pc=%h rv=%b exp v=%b i=%h pc=%h rv=%b",
                         cyc, valid_d, instr_d, pc_d, orv, ev, ei, ep, erv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_redirect();
        test_rsp_redirect();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_if_id_stage.md
Name: fetch_if_id_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register.
- Sits directly upstream of the main decoder: drives instr_d, whose [6:0] feed op and [14:12] feed Funct3.
- Issues in-order requests to instruction memory, buffers responses in a 2-entry queue, and presents one instruction per cycle to decode.
- Supports decode stall, decode flush and EX-stage PC redirect (branch/jump/jalr).

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset
XLEN  32  address/instruction width (only 32 supported)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address (word aligned)
imem_rsp_valid  in  1  response valid (in order, >=1 cycle after accept)
imem_rsp_data  in  32  instruction word
stall_d  in  1  hold IF/ID register
flush_d  in  1  load bubble into IF/ID register
redirect_valid  in  1  EX redirect request
redirect_pc  in  32  redirect target
valid_d  out  1  instr_d holds a real instruction
instr_d  out  32  instruction to decoder
pc_d  out  32  PC of instr_d
pc_plus4_d  out  32  pc_d + 4

Behaviour:
- Reset (async assert, sync release):
  - pc <= RESET_PC; queue, outstanding count and drop count <= 0.
  - valid_d=0; instr_d=32'h0 (op 0 yields all-zero controls); pc_d=0; pc_plus4_d=4.
- Issue:
  - imem_req_valid = (outstanding + q_count < 2) & ~redirect_valid & rst_n.
  - imem_req_addr = pc.
  - Fire = req_valid & req_ready: pc <= pc+4 (mod 2^32), outstanding++, and the issued pc is pushed into a 2-entry in-flight PC FIFO.
  - Request may be withdrawn or retargeted only in a redirect cycle.
- Response:
  - On rsp_valid: outstanding-- and pop in-flight PC.
  - If drop_cnt>0: discard and drop_cnt--.
  - Otherwise push {pc, data} into the queue.
  - The credit rule guarantees the queue never overflows. A push into a full queue is an assertion failure.
- IF/ID register, in priority order:
  - flush_d: bubble (valid_d=0, instr_d=0, pc_d unchanged).
  - Else stall_d: hold all outputs; queue does not pop.
  - Else if queue non-empty: pop head into instr_d/pc_d, valid_d=1.
  - Else: bubble.
  - Latency: response cycle N -> instr_d visible after edge N+1 when queue empty and not stalled.
  - Same-cycle push into an empty queue and pop are allowed (bypass not required; 1-cycle latency minimum).
- Redirect (redirect_valid=1):
  - pc <= {redirect_pc[31:2],2'b00}.
  - Queue cleared, overriding any same-cycle push.
  - drop_cnt <= outstanding minus 1 if rsp_valid this cycle (that response is discarded); no request issued.
  - Redirect does not itself clear IF/ID; EX asserts flush_d with it.
  - Redirect during stall_d still takes effect on fetch state.
- Back-to-back redirects: the second overrides pc; drop_cnt recomputed from the current outstanding count.
- pc_plus4_d always equals pc_d+4 combinationally from the pc_d register.
- Reset mid-operation: all state returns to reset values immediately. Responses for pre-reset requests are the memory's responsibility (memory reset shares rst_n).

Test Plan:
- Reset: rst_n=0 mid-stream -> req_valid=0, valid_d=0, instr_d=0; after release first req addr=RESET_PC.
- Streaming: ready=1, 1-cycle rsp of words 0x00500093,0x00a00113 -> valid_d=1 with pc_d=0,4 on consecutive cycles, pc_plus4_d=4,8.
- Stall: stall_d=1 for 3 cycles while rsp continue -> instr_d held, at most 2 outstanding+queued, req_valid drops, no lost or duplicated words after release.
- Redirect with 2 in flight: redirect_pc=0x100, flush_d=1 -> next 2 responses discarded; next valid_d shows pc_d=0x100.
- Simultaneous rsp_valid and redirect: the same-cycle response is discarded, drop_cnt=outstanding-1, and no stale PC appears at decode.
- Memory backpressure: req_ready=0 for 5 cycles -> addr stable, pc not incremented, valid_d bubbles (instr_d=0).
